// File: rtl/control_unit_risc_pkg.sv
// Shared definitions for the 8-bit RISC controller: opcodes, bus mux
// encodings, controller state codes and a register-select decode helper.
package control_unit_risc_pkg;

  localparam int word_size  = 8;
  localparam int op_size    = 4;
  localparam int state_size = 4;

  localparam logic [op_size-1:0] op_nop = 4'd0;
  localparam logic [op_size-1:0] op_add = 4'd1;
  localparam logic [op_size-1:0] op_sub = 4'd2;
  localparam logic [op_size-1:0] op_and = 4'd3;
  localparam logic [op_size-1:0] op_not = 4'd4;
  localparam logic [op_size-1:0] op_rd  = 4'd5;
  localparam logic [op_size-1:0] op_wr  = 4'd6;
  localparam logic [op_size-1:0] op_br  = 4'd7;
  localparam logic [op_size-1:0] op_brz = 4'd8;

  // bus_1 source select: register file entries, then the program counter
  localparam logic [2:0] sel1_r0 = 3'd0;
  localparam logic [2:0] sel1_r1 = 3'd1;
  localparam logic [2:0] sel1_r2 = 3'd2;
  localparam logic [2:0] sel1_r3 = 3'd3;
  localparam logic [2:0] sel1_pc = 3'd4;

  localparam logic [1:0] sel2_alu  = 2'd0;
  localparam logic [1:0] sel2_bus1 = 2'd1;
  localparam logic [1:0] sel2_mem  = 2'd2;

  typedef enum logic [state_size-1:0] {
    s_idle = 4'd0,
    s_fet1 = 4'd1,
    s_fet2 = 4'd2,
    s_dec  = 4'd3,
    s_ex1  = 4'd4,
    s_rd1  = 4'd5,
    s_rd2  = 4'd6,
    s_wr1  = 4'd7,
    s_wr2  = 4'd8,
    s_br1  = 4'd9,
    s_br2  = 4'd10,
    s_halt = 4'd11
  } state_t;

  function automatic logic [3:0] reg_onehot(input logic [1:0] r);
    return 4'b0001 << r;
  endfunction

endpackage

// File: rtl/control_unit_risc.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC datapath.
// Outputs decode combinationally from the state register (and IR in decode/execute).
//
// state  | meaning
// s_idle | post-reset, start fetch next
// s_fet1 | PC -> address reg
// s_fet2 | mem -> IR, PC+1
// s_dec  | decode; single-cycle ops complete here
// s_ex1  | ALU op result -> R[dest], Z
// s_rd1  | operand word -> address reg, PC+1
// s_rd2  | mem -> R[dest]
// s_wr1  | operand word -> address reg, PC+1
// s_wr2  | R[src] -> mem
// s_br1  | target address word -> address reg
// s_br2  | mem -> PC
// s_halt | stopped until reset
module control_unit_risc
  import control_unit_risc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 zero,
  output logic [op_size-1:0]   alu_sel,
  output logic [2:0]           sel_bus_1,
  output logic [1:0]           sel_bus_2,
  output logic [3:0]           load_reg,
  output logic                 load_pc,
  output logic                 inc_pc,
  output logic                 load_ir,
  output logic                 load_add_r,
  output logic                 load_reg_y,
  output logic                 load_reg_z,
  output logic                 write,
  output logic                 halted
);

  state_t state, state_nxt;

  logic [op_size-1:0] opcode;
  logic [1:0]         src;
  logic [1:0]         dest;

  assign opcode = instruction[7:4];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= s_idle;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    alu_sel    = '0;
    sel_bus_1  = sel1_r0;
    sel_bus_2  = sel2_alu;
    load_reg   = '0;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write      = 1'b0;
    halted     = 1'b0;

    case (state)
      s_idle: state_nxt = s_fet1;

      s_fet1: begin
        sel_bus_1  = sel1_pc;
        sel_bus_2  = sel2_bus1;
        load_add_r = 1'b1;
        state_nxt  = s_fet2;
      end

      s_fet2: begin
        sel_bus_2 = sel2_mem;
        load_ir   = 1'b1;
        inc_pc    = 1'b1;
        state_nxt = s_dec;
      end

      s_dec: begin
        case (opcode)
          op_nop: state_nxt = s_fet1;

          op_add, op_sub, op_and: begin
            sel_bus_1  = {1'b0, src};
            sel_bus_2  = sel2_bus1;
            load_reg_y = 1'b1;
            state_nxt  = s_ex1;
          end

          op_not: begin
            sel_bus_1  = {1'b0, src};
            alu_sel    = op_not;
            sel_bus_2  = sel2_alu;
            load_reg_z = 1'b1;
            load_reg   = reg_onehot(dest);
            state_nxt  = s_fet1;
          end

          op_rd, op_wr, op_br: begin
            sel_bus_1  = sel1_pc;
            sel_bus_2  = sel2_bus1;
            load_add_r = 1'b1;
            state_nxt  = (opcode == op_rd) ? s_rd1 :
                         (opcode == op_wr) ? s_wr1 : s_br1;
          end

          op_brz: begin
            if (zero) begin
              sel_bus_1  = sel1_pc;
              sel_bus_2  = sel2_bus1;
              load_add_r = 1'b1;
              state_nxt  = s_br1;
            end else begin
              // not taken: step PC over the target address word
              inc_pc    = 1'b1;
              state_nxt = s_fet1;
            end
          end

          default: state_nxt = s_halt;
        endcase
      end

      s_ex1: begin
        // ALU computes data_2 - data_1, so bus_1 carries dest for SUB = dest - src
        sel_bus_1  = {1'b0, dest};
        alu_sel    = opcode;
        sel_bus_2  = sel2_alu;
        load_reg_z = 1'b1;
        load_reg   = reg_onehot(dest);
        state_nxt  = s_fet1;
      end

      s_rd1: begin
        sel_bus_2  = sel2_mem;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_nxt  = s_rd2;
      end

      s_rd2: begin
        sel_bus_2 = sel2_mem;
        load_reg  = reg_onehot(dest);
        state_nxt = s_fet1;
      end

      s_wr1: begin
        sel_bus_2  = sel2_mem;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        state_nxt  = s_wr2;
      end

      s_wr2: begin
        sel_bus_1 = {1'b0, src};
        write     = 1'b1;
        state_nxt = s_fet1;
      end

      s_br1: begin
        sel_bus_2  = sel2_mem;
        load_add_r = 1'b1;
        state_nxt  = s_br2;
      end

      s_br2: begin
        sel_bus_2 = sel2_mem;
        load_pc   = 1'b1;
        state_nxt = s_fet1;
      end

      s_halt: begin
        halted    = 1'b1;
        state_nxt = s_halt;
      end

      default: state_nxt = s_halt;
    endcase
  end

endmodule
